// File: rtl/bp_resolve_queue.sv
// Branch-resolution queue: matches in-order resolutions against issued 2-bit predictor outputs.
// Optional BRQ_STATS_EN adds saturating resolved/mispredict counters.
module bp_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pred_valid,
    input  logic                    pred_taken,
    input  logic [IDX_W-1:0]        pred_idx,
    output logic                    pred_ready,
    input  logic                    res_valid,
    input  logic                    res_taken,
    output logic                    upd_valid,
    output logic [IDX_W-1:0]        upd_idx,
    output logic                    upd_taken,
    output logic                    mispredict,
    output logic                    res_err,
    output logic [$clog2(DEPTH):0]  count
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]             stat_resolved,
    output logic [15:0]             stat_mispred
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             taken_mem [DEPTH];
    logic [IDX_W-1:0] idx_mem   [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_taken_q, upd_taken_d;
    logic             mispredict_q, mispredict_d;
    logic             res_err_q, res_err_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             head_taken;
    logic [IDX_W-1:0] head_idx;
    logic             flush;
    logic             push_eff;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign push       = pred_valid && !full;
    assign pop        = res_valid && !empty;
    assign head_taken = taken_mem[rd_ptr_q];
    assign head_idx   = idx_mem[rd_ptr_q];
    assign flush      = pop && (head_taken != res_taken);
    // A push coinciding with a flush is on the wrong path and is dropped.
    assign push_eff   = push && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (flush) begin
            wr_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = '0;
        end else begin
            if (push_eff) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case ({push_eff, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        upd_valid_d  = pop;
        upd_idx_d    = upd_idx_q;
        upd_taken_d  = upd_taken_q;
        mispredict_d = flush;
        res_err_d    = res_valid && empty;
        if (pop) begin
            upd_idx_d   = head_idx;
            upd_taken_d = res_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            upd_valid_q  <= 1'b0;
            upd_idx_q    <= '0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            upd_valid_q  <= upd_valid_d;
            upd_idx_q    <= upd_idx_d;
            upd_taken_q  <= upd_taken_d;
            mispredict_q <= mispredict_d;
            res_err_q    <= res_err_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            taken_mem[wr_ptr_q] <= pred_taken;
            idx_mem[wr_ptr_q]   <= pred_idx;
        end
    end

    assign pred_ready = !full;
    assign upd_valid  = upd_valid_q;
    assign upd_idx    = upd_idx_q;
    assign upd_taken  = upd_taken_q;
    assign mispredict = mispredict_q;
    assign res_err    = res_err_q;
    assign count      = count_q;

`ifdef BRQ_STATS_EN
    logic [15:0] stat_resolved_q, stat_resolved_d;
    logic [15:0] stat_mispred_q, stat_mispred_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end
        return v;
    endfunction

    always_comb begin
        stat_resolved_d = sat_inc(stat_resolved_q, pop);
        stat_mispred_d  = sat_inc(stat_mispred_q, flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Bench for bp_resolve_queue: directed scenarios then random traffic against a queue-based model.
module tb_bp_resolve_queue;
    localparam int DEPTH = 4;
    localparam int IDX_W = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             mispredict;
    logic             res_err;
    logic [CNT_W-1:0] count;
`ifdef BRQ_STATS_EN
    logic [15:0]      stat_resolved;
    logic [15:0]      stat_mispred;
`endif

    bp_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .pred_ready (pred_ready),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .mispredict (mispredict),
        .res_err    (res_err),
        .count      (count)
`ifdef BRQ_STATS_EN
        ,
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             taken;
        logic [IDX_W-1:0] idx;
    } ent_t;

    ent_t mq[$];
    int   checks = 0;
    int   errors = 0;
    int   n_res  = 0;
    int   n_mis  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic pv, input logic pt,
                        input logic [IDX_W-1:0] pi, input logic rv, input logic rt);
        logic             e_uv, e_ut, e_mis, e_err;
        logic [IDX_W-1:0] e_ui;
        ent_t             h;
        bit               can_push;
        rst = r; pred_valid = pv; pred_taken = pt; pred_idx = pi;
        res_valid = rv; res_taken = rt;
        e_uv = 1'b0; e_ut = 1'b0; e_mis = 1'b0; e_err = 1'b0; e_ui = '0;
        can_push = pv && (mq.size() < DEPTH);
        if (r) begin
            mq.delete();
            n_res = 0;
            n_mis = 0;
        end else begin
            if (rv && mq.size() == 0) begin
                e_err = 1'b1;
            end else if (rv) begin
                h = mq.pop_front();
                e_uv = 1'b1;
                e_ui = h.idx;
                e_ut = rt;
                n_res++;
                if (h.taken != rt) begin
                    e_mis = 1'b1;
                    n_mis++;
                    can_push = 0;
                    mq.delete();
                end
            end
            if (can_push) mq.push_back({pt, pi});
        end
        @(posedge clk);
        #1;
        chk("upd_valid", 32'(upd_valid), 32'(e_uv));
        chk("mispredict", 32'(mispredict), 32'(e_mis));
        chk("res_err", 32'(res_err), 32'(e_err));
        chk("count", 32'(count), 32'(mq.size()));
        chk("pred_ready", 32'(pred_ready), 32'(mq.size() < DEPTH));
        if (e_uv || r) begin
            chk("upd_idx", 32'(upd_idx), 32'(e_ui));
            chk("upd_taken", 32'(upd_taken), 32'(e_ut));
        end
`ifdef BRQ_STATS_EN
        chk("stat_resolved", 32'(stat_resolved), 32'(n_res));
        chk("stat_mispred", 32'(stat_mispred), 32'(n_mis));
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; pred_valid = 1'b0; pred_taken = 1'b0; pred_idx = '0;
        res_valid = 1'b0; res_taken = 1'b0;
        step(1, 0, 0, '0, 0, 0);
        idle();

        // Two correct predictions resolved in order
        step(0, 1, 1, 4'd3, 0, 0);
        step(0, 1, 0, 4'd5, 0, 0);
        step(0, 0, 0, '0, 1, 1);
        step(0, 0, 0, '0, 1, 0);
        idle();

        // Fill, overflow push dropped, drain in order
        step(0, 1, 1, 4'd10, 0, 0);
        step(0, 1, 0, 4'd11, 0, 0);
        step(0, 1, 1, 4'd12, 0, 0);
        step(0, 1, 0, 4'd13, 0, 0);
        step(0, 1, 1, 4'd14, 0, 0);
        step(0, 1, 1, 4'd15, 1, 1);
        step(0, 0, 0, '0, 1, 0);
        step(0, 0, 0, '0, 1, 1);
        step(0, 0, 0, '0, 1, 0);
        idle();

        // Mispredict flushes younger entries and a same-cycle push
        step(0, 1, 1, 4'd1, 0, 0);
        step(0, 1, 1, 4'd2, 0, 0);
        step(0, 1, 0, 4'd7, 0, 0);
        step(0, 1, 1, 4'd6, 1, 0);
        step(0, 1, 1, 4'd9, 0, 0);
        step(0, 0, 0, '0, 1, 1);

        // Empty resolve
        step(0, 0, 0, '0, 1, 1);
        idle();

        // Push + correct pop at count 2, and at count 3
        step(0, 1, 0, 4'd4, 0, 0);
        step(0, 1, 1, 4'd8, 0, 0);
        step(0, 1, 0, 4'd2, 1, 0);
        step(0, 1, 0, 4'd3, 0, 0);
        step(0, 1, 1, 4'd5, 1, 1);

        // Reset mid-operation drops entries silently
        step(1, 0, 0, '0, 1, 1);
        step(0, 0, 0, '0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic r, pv, rv;
            r  = ($urandom_range(0, 59) == 0);
            pv = ($urandom_range(0, 99) < 60);
            rv = ($urandom_range(0, 99) < 45);
            step(r, pv, 1'($urandom), 4'($urandom), rv, ($urandom_range(0, 99) < 70));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
